aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
- Sequential AES-128 inverse key schedule: the counterpart of the forward combinational key expansion.
- Loads the final round key (round NR) and walks the schedule backwards, emitting round keys NR, NR-1, ..., 0 one at a time over a valid/ready handshake.
- Feeds the decrypt datapath with on-the-fly round keys, so no (NR+1)*128-bit expanded-key store is needed.

Parameters:
- NR, 10, number of rounds; NR+1 round keys emitted; legal range 1..10 (Rcon table limit).
- NK, 4, key words; fixed at 4 (AES-128 only); any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load last_key and begin a sequence; accepted only when busy=0.
- last_key  in  [0:127]  round-NR key, big-endian word order w[4NR]..w[4NR+3]; sampled on the accepted start.
- busy  out  1  high from the accepted start through the acceptance of round 0.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer ready.
- rk  out  [0:127]  current round key.
- rk_round  out  [3:0]  round index of rk.
- done  out  1  single-cycle pulse on the cycle after round 0 is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, rk_valid=0, rk=0, rk_round=0, done=0.
- FSM IDLE -> EMIT -> STEP -> EMIT ... -> IDLE.
- IDLE:
  - start=1 registers last_key into rk and sets rk_round=NR, busy=1.
  - Next state EMIT; rk_valid=1 on the following cycle (one-cycle load latency).
- EMIT:
  - rk_valid=1; rk and rk_round are held stable until rk_valid&rk_ready.
  - On a handshake with rk_round=0: go to IDLE; busy=0 and done=1 on the next cycle.
  - On a handshake with rk_round>0: go to STEP; rk_valid=0.
- STEP: with current words a,b,c,d (a=rk[0:31]), compute in one cycle:
  - d' = d^c; c' = c^b; b' = b^a.
  - a' = a ^ SubWord(RotWord(d')) ^ Rcon(rk_round).
  - RotWord rotates left by one byte; SubWord is the AES S-box per byte; Rcon(r) = {01,02,04,08,10,20,40,80,1b,36}[r-1] in byte 0, bytes 1..3 zero.
  - Register rk={a',b',c',d'}, decrement rk_round, return to EMIT.
- Throughput: one round key per 2 cycles at rk_ready=1. Total from start acceptance to done: 2*(NR+1)+1 cycles.
- start while busy=1: ignored, no effect.
- rk_ready high outside EMIT: ignored.
- rst_n asserted mid-sequence: immediate return to IDLE with reset values; no done pulse.
- A back-to-back start is accepted in the cycle done is high (busy=0 then).

Optional Feature:
- INV_KEY_SERIAL_SBOX_EN defined: a single S-box instance processes one byte of RotWord(d') per cycle, so STEP lasts 4 cycles. An internal 2-bit byte counter runs 0..3; a' is registered after byte 3. Latency per round key = 5 cycles; outputs and handshake are otherwise identical.
- Undefined: four parallel S-boxes; STEP lasts 1 cycle.

Decomposition:
- Package aes_key_pkg holds:
  - NK constant;
  - state enum typedef {IDLE, EMIT, STEP};
  - Rcon constant table;
  - word typedef [0:31].
- One sub-module aes_sbox (8-bit combinational forward S-box). It is instantiated four times, or once under INV_KEY_SERIAL_SBOX_EN.

Test Plan:
- FIPS-197 A.1: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> first rk equals the input with rk_round=10; second rk=ac7766f319fadc2128d12941575c006e with rk_round=9; last rk=2b7e151628aed2a6abf7158809cf4f3c with rk_round=0; done pulses once, 23 cycles after start.
- Backpressure: hold rk_ready=0 for 5 cycles at rk_round=7 -> rk_valid stays 1 and rk/rk_round stay constant; the sequence resumes correctly when rk_ready=1.
- start pulsed while busy (at rk_round=5) -> ignored; the sequence completes with the original key chain.
- rst_n low at rk_round=4 -> outputs return to reset values immediately and no done pulse; a fresh start afterwards yields the A.1 sequence.
- Random 128-bit keys vs. forward expansion model (NR=10, also NR=1) -> the emitted keys equal the model's round keys in reverse order; repeat with INV_KEY_SERIAL_SBOX_EN (5-cycle spacing).

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule.
package aes_key_pkg;

    localparam int NK = 4;

    typedef enum logic [1:0] {IDLE, EMIT, STEP} state_e;

    typedef logic [0:31] word_t;

    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Rcon for round r (1..10); zero elsewhere so idle states stay quiet.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 10; i++)
            if (r == 4'(i + 1)) v = RCON[i];
        return v;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream bus: start/last_key load plus valid/ready round-key output.
interface aes_inv_key_sched_if;
    logic           start;
    logic [0:127]   last_key;
    logic           busy;
    logic           rk_valid;
    logic           rk_ready;
    logic [0:127]   rk;
    logic [3:0]     rk_round;
    logic           done;

    modport slave  (input start, last_key, rk_ready,
                    output busy, rk_valid, rk, rk_round, done);
    modport master (output start, last_key, rk_ready,
                    input busy, rk_valid, rk, rk_round, done);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (single byte).
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: emits round keys NR..0 from the final round key.
// Optional INV_KEY_SERIAL_SBOX_EN: one shared S-box, 4-cycle STEP.
module aes_inv_key_sched #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_inv_key_sched_if.slave bus
);
    import aes_key_pkg::*;

    if (NK != aes_key_pkg::NK) begin : g_bad_nk
        $error("aes_inv_key_sched: only NK=4 (AES-128) is supported");
    end
    if (NR < 1 || NR > 10) begin : g_bad_nr
        $error("aes_inv_key_sched: NR must be within 1..10");
    end

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   rk_round_q, rk_round_d;

    word_t a, b, c, d, a_n, b_n, c_n, d_n, rot, sub_word;
    logic  step_last;

    assign a   = rk_q[0:31];
    assign b   = rk_q[32:63];
    assign c   = rk_q[64:95];
    assign d   = rk_q[96:127];
    assign d_n = d ^ c;
    assign c_n = c ^ b;
    assign b_n = b ^ a;
    assign rot = rot_word(d_n);
    assign a_n = a ^ sub_word ^ {rcon(rk_round_q), 24'h0};

`ifdef INV_KEY_SERIAL_SBOX_EN
    // Bytes 0..2 of SubWord are parked here; byte 3 comes straight from the S-box.
    logic [1:0]  cnt_q, cnt_d;
    logic [0:23] sub_q, sub_d;
    logic [7:0]  sb_in, sb_out;

    assign sb_in = rot[8*cnt_q +: 8];
    aes_sbox u_sbox (.in_byte(sb_in), .out_byte(sb_out));
    assign sub_word  = {sub_q, sb_out};
    assign step_last = (cnt_q == 2'd3);
`else
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.in_byte(rot[8*g +: 8]), .out_byte(sub_word[8*g +: 8]));
    end
    assign step_last = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        rk_d       = rk_q;
        rk_round_d = rk_round_q;
`ifdef INV_KEY_SERIAL_SBOX_EN
        cnt_d      = cnt_q;
        sub_d      = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rk_d       = bus.last_key;
                    rk_round_d = 4'(NR);
                    busy_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    rk_valid_d = 1'b0;
                    if (rk_round_q == 4'd0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
`ifdef INV_KEY_SERIAL_SBOX_EN
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    sub_d[0:7]   = sb_out;
                    2'd1:    sub_d[8:15]  = sb_out;
                    2'd2:    sub_d[16:23] = sb_out;
                    default: ;
                endcase
`endif
                if (step_last) begin
                    rk_d       = {a_n, b_n, c_n, d_n};
                    rk_round_d = rk_round_q - 4'd1;
                    rk_valid_d = 1'b1;
                    state_d    = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rk_q       <= '0;
            rk_round_q <= '0;
`ifdef INV_KEY_SERIAL_SBOX_EN
            cnt_q      <= '0;
            sub_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            rk_q       <= rk_d;
            rk_round_q <= rk_round_d;
`ifdef INV_KEY_SERIAL_SBOX_EN
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.done     = done_q;
    assign bus.rk       = rk_q;
    assign bus.rk_round = rk_round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: NR=10 and NR=1 instances against a forward-expansion model.
module tb_aes_inv_key_sched;

`ifdef INV_KEY_SERIAL_SBOX_EN
    localparam int STEP_CYC = 4;
`else
    localparam int STEP_CYC = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_key_sched_if bus ();
    aes_inv_key_sched_if bus1 ();

    assign bus1.start    = bus.start;
    assign bus1.last_key = bus.last_key;
    assign bus1.rk_ready = bus.rk_ready;

    aes_inv_key_sched #(.NR(10), .NK(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    aes_inv_key_sched #(.NR(1),  .NK(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    // Observed DUT: 0 = NR=10 instance, 1 = NR=1 instance.
    bit           sel = 1'b0;
    logic         o_valid, o_done, o_busy;
    logic [0:127] o_rk;
    logic [3:0]   o_round;
    always_comb begin
        o_valid = sel ? bus1.rk_valid : bus.rk_valid;
        o_done  = sel ? bus1.done     : bus.done;
        o_busy  = sel ? bus1.busy     : bus.busy;
        o_rk    = sel ? bus1.rk       : bus.rk;
        o_round = sel ? bus1.rk_round : bus.rk_round;
    end

    // ---------------- reference model ----------------
    logic [7:0]   sbox_t [256];
    logic [0:127] model_rk [11];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, aa, bb;
        p = 0; aa = x; bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard FIPS-197 forward expansion of a cipher key into model_rk[0..10].
    task automatic fwd_expand(input logic [0:127] key);
        logic [0:31] w [44];
        logic [0:31] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[8:31], t[0:7]};
                t = {sbox_t[t[0:7]], sbox_t[t[8:15]], sbox_t[t[16:23]], sbox_t[t[24:31]]};
                t[0:7] = t[0:7] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- sequence driver / recorder ----------------
    logic [0:127] got_key [16];
    int           got_rnd [16];
    int           hs_cyc  [16];
    int           got_n, done_cnt, done_at, hold_bad, timeout;

    task automatic run_seq(input logic [0:127] key, input int stall_rnd, input int poke_rnd,
                           input bit rnd_ready, input bit b2b, input logic [0:127] b2b_key);
        int cyc, stall_left, extra;
        logic [0:127] snap_k;
        logic [3:0]   snap_r;
        bit seen_done;
        got_n = 0; done_cnt = 0; done_at = -1; hold_bad = 0; timeout = 0;
        stall_left = 5; extra = 0; seen_done = 0; snap_k = '0; snap_r = '0;
        cyc = 0;
        bus.start = 1'b0; bus.rk_ready = 1'b1;
        while ((bus.busy || bus1.busy) && cyc < 400) begin
            @(posedge clk); #1; cyc++;
        end
        bus.last_key = key; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (1) begin
            if (cyc > 400) begin timeout = 1; break; end
            bus.start = 1'b0;
            if (o_done) begin
                done_cnt++;
                if (!seen_done) done_at = cyc;
                seen_done = 1;
                if (b2b) begin
                    bus.last_key = b2b_key; bus.start = 1'b1; bus.rk_ready = 1'b0;
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                    break;
                end
            end
            if (seen_done) begin
                if (extra == 2) break;
                extra++;
            end
            bus.rk_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_left > 0 && stall_left < 5) begin
                if (!o_valid || o_rk !== snap_k || o_round !== snap_r) hold_bad++;
                bus.rk_ready = 1'b0; stall_left--;
            end else if (stall_left == 5 && o_valid && int'(o_round) == stall_rnd) begin
                snap_k = o_rk; snap_r = o_round;
                bus.rk_ready = 1'b0; stall_left--;
            end
            if (o_valid && int'(o_round) == poke_rnd) begin
                bus.start = 1'b1; bus.last_key = ~key;
            end
            if (o_valid && bus.rk_ready && got_n < 16) begin
                got_key[got_n] = o_rk; got_rnd[got_n] = int'(o_round); hs_cyc[got_n] = cyc;
                got_n++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.start = 1'b0;
    endtask

    // ---------------- tests ----------------
    localparam logic [0:127] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;

    task automatic test_reset();
        bus.start = 1'b0; bus.rk_ready = 1'b0; bus.last_key = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl: busy/valid/done=%b expected 000", {bus.busy, bus.rk_valid, bus.done}); end
        checks++; if (bus.rk !== 128'h0 || bus.rk_round !== 4'd0) begin errors++;
            $display("FAIL reset_rk: rk=%h round=%0d expected 0/0", bus.rk, bus.rk_round); end
        checks++; if (bus1.rk_valid !== 1'b0 || bus1.busy !== 1'b0) begin errors++;
            $display("FAIL reset_nr1: valid=%b busy=%b expected 0/0", bus1.rk_valid, bus1.busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Checks a completed NR=10 run with ready held high against model_rk.
    task automatic test_fips_a1();
        sel = 0;
        fwd_expand(A1_KEY);
        checks++; if (model_rk[10] !== A1_LAST) begin errors++;
            $display("FAIL model_a1: model round10=%h expected %h", model_rk[10], A1_LAST); end
        run_seq(A1_LAST, -1, -1, 0, 0, '0);
        checks++; if (got_n !== 11 || timeout !== 0) begin errors++;
            $display("FAIL a1_count: keys=%0d timeout=%0d expected 11/0", got_n, timeout); end
        checks++; if (got_key[0] !== A1_LAST || got_rnd[0] !== 10) begin errors++;
            $display("FAIL a1_first: rk=%h round=%0d expected %h/10", got_key[0], got_rnd[0], A1_LAST); end
        checks++; if (got_key[1] !== A1_R9 || got_rnd[1] !== 9) begin errors++;
            $display("FAIL a1_second: rk=%h round=%0d expected %h/9", got_key[1], got_rnd[1], A1_R9); end
        checks++; if (got_key[10] !== A1_KEY || got_rnd[10] !== 0) begin errors++;
            $display("FAIL a1_last: rk=%h round=%0d expected %h/0", got_key[10], got_rnd[10], A1_KEY); end
        for (int j = 0; j < 11; j++) begin
            checks++; if (got_key[j] !== model_rk[10-j] || got_rnd[j] !== 10 - j) begin errors++;
                $display("FAIL a1_chain[%0d]: rk=%h round=%0d expected %h/%0d", j, got_key[j], got_rnd[j], model_rk[10-j], 10 - j); end
        end
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL a1_done_pulses: %0d expected 1", done_cnt); end
        // Inclusive window from the start cycle to the done cycle.
        checks++; if (done_at + 2 !== 10 * (STEP_CYC + 1) + 3) begin errors++;
            $display("FAIL a1_latency: %0d cycles expected %0d", done_at + 2, 10 * (STEP_CYC + 1) + 3); end
        checks++; if (hs_cyc[0] !== 0) begin errors++;
            $display("FAIL a1_load_latency: first handshake at %0d expected 0", hs_cyc[0]); end
        for (int j = 1; j < 11; j++) begin
            checks++; if (hs_cyc[j] - hs_cyc[j-1] !== STEP_CYC + 1) begin errors++;
                $display("FAIL a1_spacing[%0d]: %0d expected %0d", j, hs_cyc[j] - hs_cyc[j-1], STEP_CYC + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] k;
        sel = 0;
        k = {$urandom, $urandom, $urandom, $urandom};
        fwd_expand(k);
        run_seq(model_rk[10], 7, -1, 0, 0, '0);
        checks++; if (hold_bad !== 0) begin errors++;
            $display("FAIL bp_hold: %0d unstable cycles expected 0", hold_bad); end
        checks++; if (got_n !== 11) begin errors++;
            $display("FAIL bp_count: %0d expected 11", got_n); end
        for (int j = 0; j < 11; j++) begin
            checks++; if (got_key[j] !== model_rk[10-j] || got_rnd[j] !== 10 - j) begin errors++;
                $display("FAIL bp_chain[%0d]: rk=%h round=%0d expected %h/%0d", j, got_key[j], got_rnd[j], model_rk[10-j], 10 - j); end
        end
    endtask

    task automatic test_start_while_busy();
        sel = 0;
        fwd_expand(A1_KEY);
        run_seq(A1_LAST, -1, 5, 0, 0, '0);
        checks++; if (got_n !== 11 || done_cnt !== 1) begin errors++;
            $display("FAIL poke_count: keys=%0d done=%0d expected 11/1", got_n, done_cnt); end
        for (int j = 0; j < 11; j++) begin
            checks++; if (got_key[j] !== model_rk[10-j]) begin errors++;
                $display("FAIL poke_chain[%0d]: rk=%h expected %h", j, got_key[j], model_rk[10-j]); end
        end
    endtask

    task automatic test_reset_midseq();
        int cyc;
        int done_seen;
        sel = 0;
        bus.last_key = A1_LAST; bus.start = 1'b1; bus.rk_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'd4) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        checks++; if (cyc >= 200) begin errors++;
            $display("FAIL rstmid_reach: round 4 not reached, got round %0d", bus.rk_round); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000 || bus.rk !== 128'h0 || bus.rk_round !== 4'd0) begin errors++;
            $display("FAIL rstmid_clear: busy=%b valid=%b done=%b rk=%h round=%0d expected all 0",
                     bus.busy, bus.rk_valid, bus.done, bus.rk, bus.rk_round); end
        done_seen = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.done) done_seen++; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (bus.done) done_seen++; end
        checks++; if (done_seen !== 0) begin errors++;
            $display("FAIL rstmid_nodone: %0d done pulses expected 0", done_seen); end
        fwd_expand(A1_KEY);
        run_seq(A1_LAST, -1, -1, 0, 0, '0);
        checks++; if (got_n !== 11 || got_key[1] !== A1_R9 || got_key[10] !== A1_KEY) begin errors++;
            $display("FAIL rstmid_restart: keys=%0d r9=%h r0=%h expected 11/%h/%h", got_n, got_key[1], got_key[10], A1_R9, A1_KEY); end
    endtask

    task automatic test_random_keys();
        logic [0:127] k;
        sel = 0;
        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(k);
            run_seq(model_rk[10], -1, -1, (t == 2), 0, '0);
            checks++; if (got_n !== 11 || done_cnt !== 1) begin errors++;
                $display("FAIL rnd10_count[%0d]: keys=%0d done=%0d expected 11/1", t, got_n, done_cnt); end
            for (int j = 0; j < 11; j++) begin
                checks++; if (got_key[j] !== model_rk[10-j] || got_rnd[j] !== 10 - j) begin errors++;
                    $display("FAIL rnd10[%0d][%0d]: rk=%h round=%0d expected %h/%0d", t, j, got_key[j], got_rnd[j], model_rk[10-j], 10 - j); end
            end
        end
    endtask

    task automatic test_random_nr1();
        logic [0:127] k;
        sel = 1;
        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(k);
            run_seq(model_rk[1], -1, -1, 0, 0, '0);
            checks++; if (got_n !== 2 || done_cnt !== 1) begin errors++;
                $display("FAIL rnd1_count[%0d]: keys=%0d done=%0d expected 2/1", t, got_n, done_cnt); end
            checks++; if (got_key[0] !== model_rk[1] || got_key[1] !== model_rk[0] || got_rnd[0] !== 1 || got_rnd[1] !== 0) begin errors++;
                $display("FAIL rnd1_keys[%0d]: %h/%0d %h/%0d expected %h/1 %h/0", t,
                         got_key[0], got_rnd[0], got_key[1], got_rnd[1], model_rk[1], model_rk[0]); end
            checks++; if (done_at + 2 !== 1 * (STEP_CYC + 1) + 3) begin errors++;
                $display("FAIL rnd1_latency[%0d]: %0d expected %0d", t, done_at + 2, STEP_CYC + 4); end
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        logic [0:127] k2;
        int cyc;
        sel = 0;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        run_seq(A1_LAST, -1, -1, 0, 1, k2);
        checks++; if (bus.busy !== 1'b1 || bus.rk_valid !== 1'b1 || bus.rk !== k2 || bus.rk_round !== 4'd10) begin errors++;
            $display("FAIL b2b_accept: busy=%b valid=%b rk=%h round=%0d expected 1/1/%h/10",
                     bus.busy, bus.rk_valid, bus.rk, bus.rk_round, k2); end
        bus.rk_ready = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 400) begin @(posedge clk); #1; cyc++; end
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL b2b_drain: busy=%b expected 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0; bus.rk_ready = 1'b0; bus.last_key = '0;
        build_sbox();
        test_reset();
        test_fips_a1();
        test_backpressure();
        test_start_while_busy();
        test_reset_midseq();
        test_random_keys();
        test_random_nr1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
